enigma_rotor_stage: RTL and testbench

Parametrised, clocked Enigma rotor stage that replaces the fixed single-direction combinational rotor lookups. It holds a runtime-loadable wiring table with an auto-maintained inverse, so one instance serves both the forward and the reflected (reverse) pass. It also holds its own position, ring setting and turnover notch, and generates the carry that steps the next rotor. It sits in the rotor chain between the plugboard and the reflector, with a valid/ready handshake on the character path.

---
 rtl/enigma_rotor_stage.sv | 135 +++++++++++++
 tb/tb_enigma_rotor_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_stage.sv
// Enigma rotor stage: a loadable wiring table with an automatically maintained
// inverse, rotor position with ring offset, turnover carry, and one output
// register behind a valid/ready handshake.
// Optional build macro: ENIGMA_DOUBLE_STEP_EN. When it is defined, the rotor
// also steps itself at the notch (the historical middle-rotor double step).
module enigma_rotor_stage #(
    parameter int ALPHA = 26,
    parameter int W     = 5,
    parameter int NOTCH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_char,
    input  logic         in_dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_char,
    input  logic         step_tick,
    input  logic         step_in,
    output logic         carry_out,
    input  logic         pos_load,
    input  logic [W-1:0] pos_init,
    input  logic [W-1:0] ring,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_addr,
    input  logic [W-1:0] cfg_data,
    output logic [W-1:0] pos
);

    localparam logic [W:0]   ALPHA_X = (W+1)'(ALPHA);
    localparam logic [W-1:0] NOTCH_P = W'(NOTCH);
    localparam logic [W-1:0] LAST_P  = W'(ALPHA - 1);
    // Enough conditional subtractions to fold any W-bit value into 0..ALPHA-1.
    localparam int           FOLDS   = (2 ** W) / ALPHA;

    logic [W-1:0] fwd [ALPHA];
    logic [W-1:0] inv [ALPHA];

    logic         cfg_ok;
    logic         accept;
    logic         advance;
    logic         char_ok;
    logic [W-1:0] ring_m;
    logic [W-1:0] char_m;
    logic [W-1:0] idx;
    logic [W-1:0] v;
    logic [W-1:0] res;

    // Reduce an arbitrary W-bit value into the alphabet range.
    function automatic logic [W-1:0] mod_fix(input logic [W-1:0] a);
        logic [W:0] s;
        s = {1'b0, a};
        for (int k = 0; k < FOLDS; k++) begin
            if (s >= ALPHA_X) s = s - ALPHA_X;
        end
        return s[W-1:0];
    endfunction

    // (a + b) mod ALPHA for operands already inside the alphabet.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_X) s = s - ALPHA_X;
        return s[W-1:0];
    endfunction

    // (a - b) mod ALPHA; biasing by ALPHA keeps the W+1 bit sum non-negative.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + ALPHA_X - {1'b0, b};
        if (s >= ALPHA_X) s = s - ALPHA_X;
        return s[W-1:0];
    endfunction

    assign cfg_ok    = cfg_we && ({1'b0, cfg_addr} < ALPHA_X) && ({1'b0, cfg_data} < ALPHA_X);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign carry_out = step_tick && (pos == NOTCH_P);

`ifdef ENIGMA_DOUBLE_STEP_EN
    assign advance = step_in || (step_tick && (pos == NOTCH_P));
`else
    assign advance = step_in;
`endif

    // Character path through the rotor, using the pre-step position.
    always_comb begin
        char_ok = ({1'b0, in_char} < ALPHA_X);
        ring_m  = mod_fix(ring);
        char_m  = char_ok ? in_char : '0;
        idx     = mod_sub(mod_add(char_m, pos), ring_m);
        v       = in_dir ? inv[idx] : fwd[idx];
        res     = char_ok ? mod_add(mod_sub(v, pos), ring_m) : in_char;
    end

    // Wiring table and its inverse are written together so they stay paired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALPHA; i++) begin
                fwd[i] <= W'(i);
                inv[i] <= W'(i);
            end
        end else if (cfg_ok) begin
            fwd[cfg_addr] <= cfg_data;
            inv[cfg_data] <= cfg_addr;
        end
    end

    // Rotor position: load wins over stepping; stepping wraps at the end of the alphabet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (pos_load) begin
            pos <= mod_fix(pos_init);
        end else if (advance) begin
            pos <= (pos == LAST_P) ? '0 : pos + W'(1);
        end
    end

    // Single output register; the result holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_char  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_char  <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Self-checking bench for enigma_rotor_stage: directed vectors, hand-written
// handshake/reset/stepping sequences, and a randomized run against a model.
module tb_enigma_rotor_stage;

    localparam int ALPHA = 26;
    localparam int W     = 5;
    localparam int NOTCH = 4;
`ifdef ENIGMA_DOUBLE_STEP_EN
    localparam bit DOUBLE_STEP = 1'b1;
`else
    localparam bit DOUBLE_STEP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_dir;
    logic [W-1:0] in_char;
    logic         out_valid, out_ready;
    logic [W-1:0] out_char;
    logic         step_tick, step_in, carry_out;
    logic         pos_load;
    logic [W-1:0] pos_init, ring;
    logic         cfg_we;
    logic [W-1:0] cfg_addr, cfg_data;
    logic [W-1:0] pos;

    int checks = 0;
    int fails  = 0;

    enigma_rotor_stage #(.ALPHA(ALPHA), .W(W), .NOTCH(NOTCH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .step_tick(step_tick), .step_in(step_in), .carry_out(carry_out),
        .pos_load(pos_load), .pos_init(pos_init), .ring(ring),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pos(pos)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model state
    int fwd_m [ALPHA];
    int inv_m [ALPHA];
    int pos_m;
    bit ov_m;
    int oc_m;

    int table_w [ALPHA] = '{7,0,14,2,9,21,5,23,1,19,11,4,24,22,25,13,8,6,18,3,16,15,20,12,10,17};

    typedef struct {
        int c; int d; int p; int r; int exp;
    } vec_t;

    function automatic int modp(int x);
        return ((x % ALPHA) + ALPHA) % ALPHA;
    endfunction

    function automatic int ref_out(int c, int d, int p, int r);
        int idx, v;
        if (c >= ALPHA) return c;
        idx = modp(c + p - r);
        v   = d ? inv_m[idx] : fwd_m[idx];
        return modp(v - p + r);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_char = '0; in_dir = 0; out_ready = 1;
        step_tick = 0; step_in = 0; pos_load = 0; pos_init = '0;
        cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic cfg_write(int a, int d);
        @(negedge clk);
        cfg_we = 1; cfg_addr = W'(a); cfg_data = W'(d);
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic load_table();
        for (int i = 0; i < ALPHA; i++) begin
            @(negedge clk);
            cfg_we = 1; cfg_addr = W'(i); cfg_data = W'(table_w[i]);
            fwd_m[i] = table_w[i];
            inv_m[table_w[i]] = i;
        end
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic set_pos(int p);
        @(negedge clk);
        pos_load = 1; pos_init = W'(p);
        @(negedge clk);
        pos_load = 0;
    endtask

    task automatic send(int c, int d, int exp, string name);
        @(negedge clk);
        in_valid = 1; in_char = W'(c); in_dir = d[0];
        @(posedge clk);
        #1;
        in_valid = 0;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_char"}, out_char, exp);
    endtask

    initial begin
        vec_t vecs [6];
        int   p0;
        bit   rdy_m, carry_m, acc;

        vecs[0] = '{c:2,  d:0, p:0, r:0, exp:14};
        vecs[1] = '{c:14, d:1, p:0, r:0, exp:2};
        vecs[2] = '{c:0,  d:0, p:1, r:0, exp:25};
        vecs[3] = '{c:5,  d:0, p:3, r:1, exp:21};
        vecs[4] = '{c:0,  d:1, p:2, r:4, exp:14};
        vecs[5] = '{c:30, d:1, p:3, r:5, exp:30};

        idle_inputs();
        ring  = '0;
        rst_n = 0;
        #12;
        check("reset_pos", pos, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_char", out_char, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;

        send(7, 0, 7, "identity");

        // Out-of-range writes must leave the identity table intact
        cfg_write(26, 3);
        cfg_write(3, 30);
        send(3, 0, 3, "oob_fwd");
        send(3, 1, 3, "oob_inv");

        // Lookup in the same cycle as a write sees the old contents
        @(negedge clk);
        cfg_we = 1; cfg_addr = 5'd2; cfg_data = 5'd14;
        in_valid = 1; in_char = 5'd2; in_dir = 0;
        @(posedge clk);
        #1;
        in_valid = 0; cfg_we = 0;
        check("rw_same_cycle", out_char, 2);

        load_table();
        for (int i = 0; i < 6; i++) begin
            set_pos(vecs[i].p);
            ring = W'(vecs[i].r);
            send(vecs[i].c, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));
        end
        ring = '0;

        set_pos(27);
        check("pos_load_mod", pos, 1);

        set_pos(25);
        @(negedge clk);
        step_in = 1;
        @(negedge clk);
        step_in = 0;
        check("pos_wrap", pos, 0);

        // Turnover at the notch
        set_pos(NOTCH);
        @(negedge clk);
        step_tick = 1;
        #1;
        check("carry_at_notch", carry_out, 1);
        @(negedge clk);
        step_tick = 0;
        check("double_step", pos, DOUBLE_STEP ? 5 : 4);

        set_pos(3);
        @(negedge clk);
        step_tick = 1;
        #1;
        check("carry_off_notch", carry_out, 0);
        @(negedge clk);
        step_tick = 0;
        check("no_step_off_notch", pos, 3);

        set_pos(NOTCH);
        @(negedge clk);
        step_tick = 1; step_in = 1;
        #1;
        check("carry_with_step_in", carry_out, 1);
        @(negedge clk);
        step_tick = 0; step_in = 0;
        check("single_advance", pos, 5);

        // Backpressure and back-to-back transfer
        set_pos(0);
        @(negedge clk);
        out_ready = 0;
        in_valid = 1; in_char = 5'd2; in_dir = 0;
        @(negedge clk);
        in_char = 5'd3;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_char", out_char, 14);
            @(negedge clk);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        check("b2b_first", out_char, 2);
        check("b2b_first_valid", out_valid, 1);
        in_char = 5'd4;
        @(posedge clk);
        #1;
        check("b2b_second", out_char, 9);
        check("b2b_second_valid", out_valid, 1);
        in_valid = 0;
        @(posedge clk);
        #1;
        check("drain_valid", out_valid, 0);

        // Reset while a result is pending
        set_pos(7);
        @(negedge clk);
        out_ready = 0;
        in_valid = 1; in_char = 5'd5; in_dir = 0;
        @(negedge clk);
        in_valid = 0;
        check("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_pos", pos, 0);
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        send(2, 0, 2, "reset_identity_fwd");
        send(14, 1, 14, "reset_identity_inv");

        // Randomized run against the model
        for (int i = 0; i < ALPHA; i++) begin
            fwd_m[i] = i; inv_m[i] = i;
        end
        load_table();
        pos_m = 0;
        ov_m  = 0;
        oc_m  = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            check("rnd_valid", out_valid, ov_m);
            if (ov_m) check("rnd_char", out_char, oc_m);
            check("rnd_pos", pos, pos_m);

            if (n % 64 == 0) ring = W'($urandom_range(0, ALPHA - 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_char   = ($urandom_range(0, 9) == 0) ? W'($urandom_range(ALPHA, 31))
                                                    : W'($urandom_range(0, ALPHA - 1));
            in_dir    = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 3) != 0);
            step_tick = ($urandom_range(0, 2) == 0);
            step_in   = step_tick && ($urandom_range(0, 1) != 0);
            pos_load  = ($urandom_range(0, 15) == 0);
            pos_init  = W'($urandom_range(0, 31));
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_addr  = W'($urandom_range(0, 31));
            cfg_data  = W'($urandom_range(0, 31));
            #1;
            rdy_m   = !ov_m || out_ready;
            carry_m = step_tick && (pos_m == NOTCH);
            check("rnd_in_ready", in_ready, rdy_m);
            check("rnd_carry", carry_out, carry_m);

            acc = in_valid && rdy_m;
            if (acc) begin
                oc_m = ref_out(int'(in_char), int'(in_dir), pos_m, int'(ring));
                ov_m = 1;
            end else if (out_ready) begin
                ov_m = 0;
            end
            p0 = pos_m;
            if (pos_load)
                pos_m = int'(pos_init) % ALPHA;
            else if (step_in || (DOUBLE_STEP && carry_m))
                pos_m = (p0 + 1) % ALPHA;
            if (cfg_we && int'(cfg_addr) < ALPHA && int'(cfg_data) < ALPHA) begin
                fwd_m[int'(cfg_addr)] = int'(cfg_data);
                inv_m[int'(cfg_data)] = int'(cfg_addr);
            end
        end
        @(negedge clk);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
